str_feed_ctrl: RTL and testbench

STR_FEED_CTRL -- requirements
Module: str_feed_ctrl

---
 rtl/str_feed_ctrl.sv | 125 ++++++++++++
 tb/tb_str_feed_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/str_feed_ctrl.sv
// Byte feeder for a string recognizer: FWFT input FIFO, issue/wait controller,
// verdict edge detection with saturating counters, and an ERROR-state timeout resync.
module str_feed_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    parameter int TMO   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       state,
    output logic [7:0]       ch_data,
    output logic             valid,
    output logic             error_verify,
    output logic             str_ok,
    output logic             str_bad,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_V    = TW'(TMO);
    localparam logic [3:0]    S_STOP   = 4'd2;
    localparam logic [3:0]    S_ERROR  = 4'd3;

    typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT, C_RESYNC} cst_t;

    cst_t          cst, nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    prev_state;
    logic          full, empty, push, pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (cst == C_ISSUE);
    assign ch_data  = mem[rd_ptr];
    assign busy     = !empty || (cst != C_IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cst <= C_IDLE;
        else     cst <= nxt;
    end

    // STOP is left by the recognizer on its own, so never feed it a byte there.
    always_comb begin
        nxt          = cst;
        valid        = 1'b0;
        error_verify = 1'b0;
        case (cst)
            C_IDLE: begin
                if (!empty && state != S_STOP)
                    nxt = C_ISSUE;
                else if (state == S_ERROR && tmo_cnt == TMO_V)
                    nxt = C_RESYNC;
            end
            C_ISSUE: begin
                valid = 1'b1;
                nxt   = C_WAIT;
            end
            C_WAIT:   nxt = C_IDLE;
            C_RESYNC: begin
                error_verify = 1'b1;
                nxt          = C_IDLE;
            end
            default:  nxt = C_IDLE;
        endcase
    end

    // Counts consecutive cycles stuck in ERROR with nothing left to feed.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != S_ERROR || pop || !empty || cst == C_RESYNC)
            tmo_cnt <= '0;
        else if (tmo_cnt != TMO_V)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= '0;
            str_ok     <= 1'b0;
            str_bad    <= 1'b0;
            ok_cnt     <= '0;
            bad_cnt    <= '0;
        end else begin
            prev_state <= state;
            str_ok     <= (state == S_STOP)  && (prev_state != S_STOP);
            str_bad    <= (state == S_ERROR) && (prev_state != S_ERROR);
            if (state == S_STOP && prev_state != S_STOP && ok_cnt != '1)
                ok_cnt <= ok_cnt + 1'b1;
            if (state == S_ERROR && prev_state != S_ERROR && bad_cnt != '1)
                bad_cnt <= bad_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_str_feed_ctrl.sv
// Bench for str_feed_ctrl with a behavioural hex-8 recognizer and a byte scoreboard.
module tb_str_feed_ctrl;
    localparam int CW = 2;

    logic          clk = 0, rst;
    logic [7:0]    in_data, ch_data;
    logic          in_valid, in_ready, valid, error_verify, str_ok, str_bad, busy;
    logic [3:0]    state, rstate;
    logic [CW-1:0] ok_cnt, bad_cnt;
    logic          force_stop;

    int n_chk = 0, n_fail = 0;
    int n_valid = 0, n_sok = 0, n_sbad = 0, n_ev = 0;
    int cyc = 0, t_bad = 0, t_ev = 0;
    logic [7:0] exp_q[$];

    str_feed_ctrl #(.DEPTH(8), .CNT_W(CW), .TMO(15)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .state(state), .ch_data(ch_data), .valid(valid),
        .error_verify(error_verify), .str_ok(str_ok), .str_bad(str_bad),
        .ok_cnt(ok_cnt), .bad_cnt(bad_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] rec_next(input logic [3:0] s, input logic [7:0] b);
        logic hx;
        hx = (b >= 8'h30 && b <= 8'h39) || (b >= 8'h61 && b <= 8'h66) ||
             (b >= 8'h41 && b <= 8'h46);
        case (s)
            4'd0:    return (b == 8'h00) ? 4'd1 : 4'd0;
            4'd1:    return hx ? 4'd4 : 4'd3;
            4'd3:    return (b == 8'h00) ? 4'd0 : 4'd3;
            4'd11:   return (b == 8'h00) ? 4'd2 : 4'd3;
            default: return (s >= 4'd4 && s <= 4'd10 && hx) ? s + 4'd1 : 4'd3;
        endcase
    endfunction

    assign state = force_stop ? 4'd2 : rstate;

    always_ff @(posedge clk) begin
        if (rst)                              rstate <= 4'd0;
        else if (!force_stop) begin
            if (rstate == 4'd2)               rstate <= 4'd0;
            else if (error_verify && rstate == 4'd3) rstate <= 4'd0;
            else if (valid)                   rstate <= rec_next(rstate, ch_data);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                n_valid++;
                if (exp_q.size() == 0) chk("valid_unexpected", 1, 0);
                else                   chk("ch_data", int'(ch_data), int'(exp_q.pop_front()));
            end
            if (valid && error_verify) chk("valid_ev_excl", 1, 0);
            if (str_ok)  n_sok++;
            if (str_bad) begin n_sbad++; t_bad = cyc; end
            if (error_verify) begin n_ev++; t_ev = cyc; end
        end
    end

    task automatic clr_counts();
        n_valid = 0; n_sok = 0; n_sbad = 0; n_ev = 0;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("push_timeout", 0, 1);
        in_data = b; in_valid = 1'b1;
        exp_q.push_back(b);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit need_idle);
        int n;
        n = 0;
        @(negedge clk);
        while (n < 400 && (busy || exp_q.size() != 0 || (need_idle && state != 4'd0))) begin
            @(negedge clk); n++;
        end
        if (n >= 400) chk("drain_timeout", 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic good_str();
        logic [7:0] gs [10];
        gs = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h00};
        for (int i = 0; i < 10; i++) push(gs[i]);
        wait_done(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_data = 0; force_stop = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ev", int'(error_verify), 0);
        chk("rst_cnts", int'({ok_cnt, bad_cnt}), 0);
        rst = 0;

        // good string
        clr_counts();
        good_str();
        chk("good_valids", n_valid, 10);
        chk("good_ok_pulse", n_sok, 1);
        chk("good_bad_pulse", n_sbad, 0);
        chk("good_ok_cnt", int'(ok_cnt), 1);
        chk("good_bad_cnt", int'(bad_cnt), 0);

        // bad string resynced by trailing 00
        clr_counts();
        push(8'h00); push(8'h67); push(8'h68); push(8'h00);
        wait_done(1);
        chk("bad_valids", n_valid, 4);
        chk("bad_pulse", n_sbad, 1);
        chk("bad_cnt1", int'(bad_cnt), 1);
        chk("bad_no_ev", n_ev, 0);
        chk("bad_state_idle", int'(state), 0);

        // stuck in ERROR -> timeout resync
        clr_counts();
        push(8'h00); push(8'h78);
        wait_done(1);
        chk("tmo_bad_pulse", n_sbad, 1);
        chk("tmo_ev_once", n_ev, 1);
        chk("tmo_gap", t_ev - t_bad, 15);
        chk("tmo_bad_cnt", int'(bad_cnt), 2);
        chk("tmo_state", int'(state), 0);

        // counter saturation: four more good strings, five in total
        for (int i = 0; i < 4; i++) begin
            good_str();
            chk("sat_ok_cnt", int'(ok_cnt), (i + 2 > 3) ? 3 : i + 2);
        end

        // STOP hold blocks issue; ninth byte dropped on full FIFO
        force_stop = 1;
        repeat (3) @(negedge clk);
        clr_counts();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("stop_in_ready", int'(in_ready), (i < 8) ? 1 : 0);
            in_data = (i == 0) ? 8'h00 : 8'(8'h30 + i); in_valid = 1'b1;
            if (i < 8) exp_q.push_back(in_data);
            @(posedge clk); #1 in_valid = 1'b0;
        end
        repeat (10) @(negedge clk);
        chk("stop_no_valid", n_valid, 0);
        chk("stop_busy", int'(busy), 1);
        force_stop = 0;
        wait_done(0);
        chk("stop_drain_valids", n_valid, 8);

        // reset mid-string
        push(8'h00); push(8'h31); push(8'h32); push(8'h33);
        @(negedge clk);
        rst = 1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_cnts", int'({ok_cnt, bad_cnt}), 0);
        rst = 0;
        clr_counts();
        repeat (12) @(negedge clk);
        chk("mid_rst_no_valid", n_valid, 0);
        chk("mid_rst_no_verdict", n_sok + n_sbad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
